hc_adder: RTL and testbench

- 16-bit Han-Carlson parallel-prefix adder with carry-in and carry-out; the Sum and Cout outputs are registered.
- Computes A + B + Cin through a sparse prefix tree:
  - a Kogge-Stone tree on odd bit positions;
  - one final grey-cell stage for even positions.
- Used as a pipelined arithmetic leaf cell in datapaths and adder-comparison studies.

---
 rtl/hc_adder.sv | 113 +++++++++++
 tb/tb_hc_adder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/hc_adder.sv
// hc_adder: 16-bit Han-Carlson parallel-prefix adder with registered Sum/Cout.
// Odd bits resolve through a Kogge-Stone tree (spans 1, 2, 4, 8); even bits
// pick up their carry from the completed odd neighbour in one final grey stage.
module hc_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] Sum,
    output logic        Cout
);

    logic [15:0] w_g_bit;
    logic [15:0] w_p_bit;

    // Per-stage generate/propagate vectors; index k holds the result after stage k.
    logic [15:0] w_g0, w_p0;
    logic [15:0] w_g1, w_p1;
    logic [15:0] w_g2, w_p2;
    logic [15:0] w_g3, w_p3;
    logic [15:0] w_g4, w_p4;
    logic [15:0] w_gc;

    logic [15:0] w_sum;
    logic        w_cout;

    logic [15:0] r_sum;
    logic        r_cout;

    assign w_g_bit = A & B;
    assign w_p_bit = A ^ B;

    // Carry-in folded into bit 0 so every GC term already includes it.
    assign w_g0 = {w_g_bit[15:1], w_g_bit[0] | (w_p_bit[0] & Cin)};
    assign w_p0 = w_p_bit;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_prefix
            if (gi % 2 == 1) begin : g_odd
                // Stage 1: odd bit absorbs its even neighbour.
                assign w_g1[gi] = w_g0[gi] | (w_p0[gi] & w_g0[gi-1]);
                assign w_p1[gi] = w_p0[gi] & w_p0[gi-1];

                // Stage 2: span 2 across odd bits.
                if (gi >= 2) begin : g_s2
                    assign w_g2[gi] = w_g1[gi] | (w_p1[gi] & w_g1[gi-2]);
                    assign w_p2[gi] = w_p1[gi] & w_p1[gi-2];
                end else begin : g_s2_pass
                    assign w_g2[gi] = w_g1[gi];
                    assign w_p2[gi] = w_p1[gi];
                end

                // Stage 3: span 4.
                if (gi >= 4) begin : g_s3
                    assign w_g3[gi] = w_g2[gi] | (w_p2[gi] & w_g2[gi-4]);
                    assign w_p3[gi] = w_p2[gi] & w_p2[gi-4];
                end else begin : g_s3_pass
                    assign w_g3[gi] = w_g2[gi];
                    assign w_p3[gi] = w_p2[gi];
                end

                // Stage 4: span 8.
                if (gi >= 8) begin : g_s4
                    assign w_g4[gi] = w_g3[gi] | (w_p3[gi] & w_g3[gi-8]);
                    assign w_p4[gi] = w_p3[gi] & w_p3[gi-8];
                end else begin : g_s4_pass
                    assign w_g4[gi] = w_g3[gi];
                    assign w_p4[gi] = w_p3[gi];
                end

                // Odd bits are complete after the Kogge-Stone stages.
                assign w_gc[gi] = w_g4[gi];
            end else begin : g_even
                // Even bits ride through the odd tree untouched.
                assign w_g1[gi] = w_g0[gi];
                assign w_p1[gi] = w_p0[gi];
                assign w_g2[gi] = w_g1[gi];
                assign w_p2[gi] = w_p1[gi];
                assign w_g3[gi] = w_g2[gi];
                assign w_p3[gi] = w_p2[gi];
                assign w_g4[gi] = w_g3[gi];
                assign w_p4[gi] = w_p3[gi];

                // Stage 5: grey cell with the finished odd bit below; bit 0 is already done.
                if (gi >= 2) begin : g_s5
                    assign w_gc[gi] = w_g4[gi] | (w_p4[gi] & w_gc[gi-1]);
                end else begin : g_s5_bit0
                    assign w_gc[gi] = w_g4[gi];
                end
            end
        end
    endgenerate

    assign w_sum  = w_p_bit ^ {w_gc[14:0], Cin};
    assign w_cout = w_gc[15];

    // Output register: captures the sum every edge, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= 16'h0000;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_cout;
        end
    end

    assign Sum  = r_sum;
    assign Cout = r_cout;

endmodule

// File: tb/tb_hc_adder.sv
// tb_hc_adder: directed and randomized checks of the registered 16-bit adder.
module tb_hc_adder;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic [15:0] Sum;
    logic        Cout;

    int n_pass;
    int n_total;

    hc_adder dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .Sum  (Sum),
        .Cout (Cout)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive operands at the falling edge, wait one rising edge, check 1 ns later.
    task automatic apply_check(input string name, input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic [15:0] exp_sum, input logic exp_cout);
        @(negedge clk);
        A   = a;
        B   = b;
        Cin = cin;
        @(posedge clk);
        #1;
        n_total++;
        if ({Cout, Sum} !== {exp_cout, exp_sum})
            $display("FAIL %s: got Cout=%b Sum=%h, expected Cout=%b Sum=%h",
                     name, Cout, Sum, exp_cout, exp_sum);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        A   = 16'hFFFF;
        B   = 16'hFFFF;
        Cin = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({Cout, Sum} !== 17'h0_0000)
            $display("FAIL reset_immediate: got Cout=%b Sum=%h, expected 0/0000", Cout, Sum);
        else
            n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_total++;
            if ({Cout, Sum} !== 17'h0_0000)
                $display("FAIL reset_hold%0d: got Cout=%b Sum=%h, expected 0/0000", i, Cout, Sum);
            else
                n_pass++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_total++;
        if ({Cout, Sum} !== {1'b1, 16'hFFFF})
            $display("FAIL reset_release: got Cout=%b Sum=%h, expected 1/FFFF", Cout, Sum);
        else
            n_pass++;
    endtask

    task automatic test_basic();
        apply_check("basic_0_1111", 16'h0000, 16'h1111, 1'b0, 16'h1111, 1'b0);
        apply_check("basic_1111_0", 16'h1111, 16'h0000, 1'b0, 16'h1111, 1'b0);
        apply_check("basic_1234_4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        apply_check("basic_8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        apply_check("basic_00FF_0001", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
        apply_check("basic_5555_AAAA", 16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0);
    endtask

    task automatic test_carry_in();
        apply_check("cin_0101", 16'h0101, 16'h0000, 1'b1, 16'h0102, 1'b0);
        apply_check("cin_0_0", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
        apply_check("cin_5555_AAAA", 16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1);
        apply_check("cin_7FFF_0", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0);
    endtask

    task automatic test_full_carry();
        apply_check("full_ffff_ffff_c0", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1);
        apply_check("full_ffff_ffff_c1", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        apply_check("ripple_ffff_0_c0", 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0);
        apply_check("ripple_ffff_0_c1", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        apply_check("ripple_0_ffff_c1", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1);
        apply_check("ripple_7fff_7fff_c1", 16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b;
        logic        cin;
        logic [16:0] exp;
        int          n_bad;
        n_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom);
            exp = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
            @(negedge clk);
            A   = a;
            B   = b;
            Cin = cin;
            @(posedge clk);
            #1;
            n_total++;
            if ({Cout, Sum} !== exp) begin
                n_bad++;
                if (n_bad <= 10)
                    $display("FAIL b2b[%0d] A=%h B=%h Cin=%b: got Cout=%b Sum=%h, expected Cout=%b Sum=%h",
                             i, a, b, cin, Cout, Sum, exp[16], exp[15:0]);
            end else begin
                n_pass++;
            end
            if (i == 500) begin
                // Async reset pulse mid-stream, held across one rising edge.
                #2;
                rst = 1'b1;
                #1;
                n_total++;
                if ({Cout, Sum} !== 17'h0_0000)
                    $display("FAIL b2b_rst_immediate: got Cout=%b Sum=%h, expected 0/0000", Cout, Sum);
                else
                    n_pass++;
                @(posedge clk);
                #1;
                n_total++;
                if ({Cout, Sum} !== 17'h0_0000)
                    $display("FAIL b2b_rst_hold: got Cout=%b Sum=%h, expected 0/0000", Cout, Sum);
                else
                    n_pass++;
                @(negedge clk);
                rst = 1'b0;
            end
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        A       = 16'h0000;
        B       = 16'h0000;
        Cin     = 1'b0;
        test_reset();
        test_basic();
        test_carry_in();
        test_full_carry();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
